axil_ram_slave: RTL and testbench

//  AXI4-Lite slave backed by a byte-enabled single-clock RAM. Successor to the

---
 rtl/axil_ram_slave.sv | 251 +++++++++++++++++++++++++
 tb/tb_axil_ram_slave.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axil_ram_slave
// Description : AXI4-Lite slave backed by a byte-enabled single-clock RAM,
//               with out-of-range SLVERR and registered B/R responses.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_ram_slave #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 32,
  parameter int SIZE       = 4096,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AWIDTH-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic [DWIDTH/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [AWIDTH-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DWIDTH-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int ABITS  = $clog2(SIZE);
  localparam int DEPTH  = SIZE / NBYTES;
  localparam int IDXW   = (ABITS > LSB) ? (ABITS - LSB) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  function automatic logic [IDXW-1:0] word_idx(input logic [AWIDTH-1:0] a);
    return IDXW'(a >> LSB) & IDXW'(DEPTH - 1);
  endfunction

  function automatic logic is_oor(input logic [AWIDTH-1:0] a);
    return |(a >> ABITS);
  endfunction

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] ram_rd_q;

  // Readies stay low through reset and rise on the first edge after release.
  logic out_en_q;

  w_state_t            w_state_q, w_state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [AWIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]   wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;

  r_state_t            r_state_q, r_state_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rd_oor_q, rd_oor_d;

  logic                aw_hs, w_hs, ar_hs;
  logic                commit, mem_we;
  logic [AWIDTH-1:0]   commit_addr;
  logic [DWIDTH-1:0]   commit_data;
  logic [NBYTES-1:0]   commit_strb;
  logic [IDXW-1:0]     commit_idx;

  assign awready = out_en_q && (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = out_en_q && (w_state_q == W_IDLE) && !w_held_q;
  assign arready = out_en_q && (r_state_q == R_IDLE);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;

  // A beat arriving this cycle bypasses the holding registers so the
  // commit can happen on the same edge that completes the pair.
  assign commit_addr = aw_held_q ? awaddr_q : awaddr;
  assign commit_data = w_held_q ? wdata_q : wdata;
  assign commit_strb = w_held_q ? wstrb_q : wstrb;
  assign commit_idx  = word_idx(commit_addr);
  assign mem_we      = commit && !is_oor(commit_addr);

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rresp  = rresp_q;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          commit    = 1'b1;
          bvalid_d  = 1'b1;
          bresp_d   = is_oor(commit_addr) ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rd_oor_d  = rd_oor_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_oor_d = is_oor(araddr);
          rresp_d  = is_oor(araddr) ? RESP_SLVERR : RESP_OKAY;
          if (RD_LATENCY == 2) begin
            r_state_d = R_WAIT;
          end else begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
          end
        end
      end
      R_WAIT: begin
        r_state_d = R_RESP;
        rvalid_d  = 1'b1;
      end
      R_RESP: begin
        if (rvalid_q && rready) begin
          rvalid_d  = 1'b0;
          rresp_d   = RESP_OKAY;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en_q  <= 1'b0;
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rd_oor_q  <= 1'b0;
    end else begin
      out_en_q  <= 1'b1;
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rd_oor_q  <= rd_oor_d;
    end
  end

  // RAM array is never reset; a read racing a commit to the same word sees
  // the old contents because both are non-blocking on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (commit_strb[i]) begin
          mem[commit_idx][i*8 +: 8] <= commit_data[i*8 +: 8];
        end
      end
    end
    if (ar_hs) begin
      ram_rd_q <= mem[word_idx(araddr)];
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_rd_lat2
      logic [DWIDTH-1:0] rdata_pipe_q, rdata_pipe_d;

      always_comb begin
        rdata_pipe_d = rdata_pipe_q;
        if (r_state_q == R_WAIT) begin
          rdata_pipe_d = rd_oor_q ? '0 : ram_rd_q;
        end else if (rvalid_q && rready) begin
          rdata_pipe_d = '0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_pipe_q <= '0;
        end else begin
          rdata_pipe_q <= rdata_pipe_d;
        end
      end

      assign rdata = rdata_pipe_q;
    end else begin : g_rd_lat1
      assign rdata = (rvalid_q && !rd_oor_q) ? ram_rd_q : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axil_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_ram_slave
// Description : Directed self-checking bench for axil_ram_slave, covering a
//               32-bit/latency-1 instance and a 64-bit/latency-2 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_ram_slave;

  localparam int SIZE = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel;
  logic [31:0] awaddr, araddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
  logic [1:0]  bresp_a, rresp_a;
  logic [31:0] rdata_a;
  logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
  logic [1:0]  bresp_b, rresp_b;
  logic [63:0] rdata_b;

  logic        awready_m, wready_m, bvalid_m, arready_m, rvalid_m;
  logic [1:0]  bresp_m, rresp_m;
  logic [63:0] rdata_m;

  assign awready_m = sel ? awready_b : awready_a;
  assign wready_m  = sel ? wready_b  : wready_a;
  assign bvalid_m  = sel ? bvalid_b  : bvalid_a;
  assign arready_m = sel ? arready_b : arready_a;
  assign rvalid_m  = sel ? rvalid_b  : rvalid_a;
  assign bresp_m   = sel ? bresp_b   : bresp_a;
  assign rresp_m   = sel ? rresp_b   : rresp_a;
  assign rdata_m   = sel ? rdata_b   : {32'h0, rdata_a};

  axil_ram_slave #(.DWIDTH(32), .AWIDTH(32), .SIZE(SIZE), .RD_LATENCY(1)) u_dut32 (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid & ~sel), .awready(awready_a),
    .wdata(wdata[31:0]), .wstrb(wstrb[3:0]), .wvalid(wvalid & ~sel), .wready(wready_a),
    .bresp(bresp_a), .bvalid(bvalid_a), .bready(bready & ~sel),
    .araddr(araddr), .arvalid(arvalid & ~sel), .arready(arready_a),
    .rdata(rdata_a), .rresp(rresp_a), .rvalid(rvalid_a), .rready(rready & ~sel)
  );

  axil_ram_slave #(.DWIDTH(64), .AWIDTH(32), .SIZE(SIZE), .RD_LATENCY(2)) u_dut64 (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid & sel), .awready(awready_b),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & sel), .wready(wready_b),
    .bresp(bresp_b), .bvalid(bvalid_b), .bready(bready & sel),
    .araddr(araddr), .arvalid(arvalid & sel), .arready(arready_b),
    .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rready(rready & sel)
  );

  // Reference model: byte memory per instance plus queues of expected responses.
  logic [7:0]  model_mem [2][SIZE];
  logic [1:0]  exp_b [$];
  logic [63:0] exp_rdata [$];
  logic [1:0]  exp_rresp [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within 20 cycles, expected one", name);
  endtask

  function automatic int nbytes();
    return sel ? 8 : 4;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int base;
    int m;
    m = sel ? 1 : 0;
    base = int'(a) & ~(nbytes() - 1);
    if (a < SIZE) begin
      for (int i = 0; i < nbytes(); i++) begin
        if (s[i]) model_mem[m][base + i] = d[i*8 +: 8];
      end
    end
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] a);
    logic [63:0] d;
    int base;
    int m;
    d = '0;
    m = sel ? 1 : 0;
    base = int'(a) & ~(nbytes() - 1);
    if (a < SIZE) begin
      for (int i = 0; i < nbytes(); i++) d[i*8 +: 8] = model_mem[m][base + i];
    end
    return d;
  endfunction

  // Every cycle a response is valid it must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid_m) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: bvalid=1 with resp %0h, expected no response", bresp_m);
        end else begin
          check("bresp_model", 64'(bresp_m), 64'(exp_b[0]));
          if (bready) void'(exp_b.pop_front());
        end
      end
      if (rvalid_m) begin
        if (exp_rdata.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_unexpected: rvalid=1 with data %0h, expected no response", rdata_m);
        end else begin
          check("rdata_model", rdata_m, exp_rdata[0]);
          check("rresp_model", 64'(rresp_m), 64'(exp_rresp[0]));
          if (rready) begin
            void'(exp_rdata.pop_front());
            void'(exp_rresp.pop_front());
          end
        end
      end
    end
  end

  // w_lead = cycles by which W precedes AW (0 = same cycle).
  task automatic start_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int w_lead);
    int n;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    if (w_lead == 0) begin
      awaddr = a;
      awvalid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(wready_m && (w_lead > 0 || awready_m)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout_fail("w_handshake");
    @(posedge clk); #1;
    wvalid = 1'b0;
    awvalid = 1'b0;
    if (w_lead > 0) begin
      check("wready_after_w_capture", 64'(wready_m), 64'd0);
      check("awready_while_w_held", 64'(awready_m), 64'd1);
      repeat (w_lead - 1) @(posedge clk);
      #1;
      awaddr = a;
      awvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!awready_m && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) timeout_fail("aw_handshake");
      check("bvalid_before_aw", 64'(bvalid_m), 64'd0);
      @(posedge clk); #1;
      awvalid = 1'b0;
    end
    model_write(a, d, s);
    exp_b.push_back((a >= SIZE) ? 2'b10 : 2'b00);
    check("bvalid_latency", 64'(bvalid_m), 64'd1);
  endtask

  task automatic finish_b(input int stall, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    repeat (stall) begin
      @(negedge clk);
      check("b_stall_bvalid", 64'(bvalid_m), 64'd1);
      check("b_stall_readies", 64'({awready_m, wready_m}), 64'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout_fail("b_handshake");
    resp = bresp_m;
    @(posedge clk); #1;
    check("bvalid_clear", 64'(bvalid_m), 64'd0);
    check("awready_back", 64'(awready_m), 64'd1);
  endtask

  task automatic start_read(input logic [31:0] a);
    int n;
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout_fail("ar_handshake");
    exp_rdata.push_back(model_read(a));
    exp_rresp.push_back((a >= SIZE) ? 2'b10 : 2'b00);
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (sel) begin
      check("rvalid_early_lat2", 64'(rvalid_m), 64'd0);
      @(posedge clk); #1;
    end
    check("rvalid_latency", 64'(rvalid_m), 64'd1);
  endtask

  task automatic finish_r(input int stall, output logic [63:0] d, output logic [1:0] resp);
    int n;
    d = 'x;
    resp = 2'bxx;
    repeat (stall) begin
      @(negedge clk);
      check("r_stall_rvalid", 64'(rvalid_m), 64'd1);
      check("r_stall_arready", 64'(arready_m), 64'd0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout_fail("r_handshake");
    d = rdata_m;
    resp = rresp_m;
    @(posedge clk); #1;
    check("rvalid_clear", 64'(rvalid_m), 64'd0);
    check("arready_back", 64'(arready_m), 64'd1);
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [63:0] d,
                    input logic [7:0] s, input int lead, input logic [1:0] want);
    logic [1:0] r;
    start_write(a, d, s, lead);
    finish_b(0, r);
    check(name, 64'(r), 64'(want));
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [63:0] want_d,
                    input logic [1:0] want_r);
    logic [63:0] d;
    logic [1:0]  r;
    start_read(a);
    finish_r(0, d, r);
    check(name, d, want_d);
    check({name, "_resp"}, 64'(r), 64'(want_r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r;
    logic [63:0] d;
    sel = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_readies", 64'({awready_m, wready_m, arready_m}), 64'd0);
    check("reset_valids", 64'({bvalid_m, rvalid_m}), 64'd0);
    check("reset_resps", 64'({bresp_m, rresp_m}), 64'd0);
    check("reset_rdata", rdata_m, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_edge", 64'({awready_m, wready_m, arready_m}), 64'd0);
    @(posedge clk); #1;
    check("ready_after_first_edge", 64'({awready_m, wready_m, arready_m}), 64'h7);

    // 32-bit, read latency 1
    wr("t1_bresp", 32'h10, 64'hDEADBEEF, 8'h0F, 0, 2'b00);
    rd("t1_rdata", 32'h10, 64'hDEADBEEF, 2'b00);
    wr("t2_bresp", 32'h20, 64'hA5A55A5A, 8'h0F, 3, 2'b00);
    rd("t2_rdata", 32'h20, 64'hA5A55A5A, 2'b00);
    wr("t3_bresp", 32'h10, 64'h11223344, 8'h05, 0, 2'b00);
    rd("t3_rdata", 32'h10, 64'hDE22BE44, 2'b00);
    wr("strb0_bresp", 32'h12, 64'hFFFFFFFF, 8'h00, 0, 2'b00);
    rd("strb0_rdata", 32'h10, 64'hDE22BE44, 2'b00);

    bready = 1'b0;
    start_write(32'h30, 64'h0BADF00D, 8'h0F, 0);
    finish_b(5, r);
    check("t4_bresp", 64'(r), 64'd0);
    rready = 1'b0;
    start_read(32'h30);
    finish_r(5, d, r);
    check("t4_rdata", d, 64'h0BADF00D);

    wr("t5_word0_bresp", 32'h0, 64'h01234567, 8'h0F, 0, 2'b00);
    wr("t5_oor_bresp", SIZE, 64'hFFFFFFFF, 8'h0F, 0, 2'b10);
    rd("t5_word0_intact", 32'h0, 64'h01234567, 2'b00);
    rd("t5_oor_rdata", SIZE, 64'h0, 2'b10);

    // Reset with both responses pending
    bready = 1'b0;
    rready = 1'b0;
    start_write(32'h8, 64'h55AA55AA, 8'h0F, 0);
    start_read(32'h10);
    #2 rst = 1'b1;
    #1;
    check("t6_valids_in_reset", 64'({bvalid_m, rvalid_m}), 64'd0);
    check("t6_readies_in_reset", 64'({awready_m, wready_m, arready_m}), 64'd0);
    exp_b.delete();
    exp_rdata.delete();
    exp_rresp.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bready = 1'b1;
    rready = 1'b1;
    @(posedge clk); #1;
    wr("t6_bresp", 32'h4, 64'h76543210, 8'h0F, 0, 2'b00);
    rd("t6_rdata", 32'h4, 64'h76543210, 2'b00);

    // 64-bit, read latency 2
    sel = 1'b1;
    @(posedge clk); #1;
    wr("w64_t1_bresp", 32'h10, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, 2'b00);
    rd("w64_t1_rdata", 32'h10, 64'hDEADBEEFCAFEF00D, 2'b00);
    wr("w64_t2_bresp", 32'h20, 64'h0123456789ABCDEF, 8'hFF, 3, 2'b00);
    rd("w64_t2_rdata", 32'h20, 64'h0123456789ABCDEF, 2'b00);
    wr("w64_t3_bresp", 32'h10, 64'h1122334455667788, 8'h55, 0, 2'b00);
    rd("w64_t3_rdata", 32'h14, 64'hDE22BE44CA66F088, 2'b00);
    rready = 1'b0;
    start_read(32'h20);
    finish_r(5, d, r);
    check("w64_t4_rdata", d, 64'h0123456789ABCDEF);

    @(posedge clk); #1;
    check("queues_drained", 64'(exp_b.size() + exp_rdata.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
